// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_pkg
// Purpose  : Shared definitions for the sequential shift unit. It holds the
//            operation encodings, the FSM state encoding and the default
//            width constants.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package shift_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_SHW   = 6;

   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_SLL  = 2'b01,
      OP_SRL  = 2'b10,
      OP_SRA  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_e;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ============================================================================
// Module   : shift_step
// Purpose  : Combinational one-bit-position shift of a WIDTH-bit word. The
//            operation code selects the direction and fill bit. LOAD passes
//            the word through unchanged.
// Ports    : op_i   [1:0]       operation code (shift_pkg::op_e encoding)
//            data_i [WIDTH-1:0] word to shift
//            data_o [WIDTH-1:0] word shifted by one position
// Revision : 1.0 - initial release
// ============================================================================
module shift_step
   import shift_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o
);

   always_comb begin
      data_o = data_i;
      unique case (op_e'(op_i))
         OP_SLL:  data_o = {data_i[WIDTH-2:0], 1'b0};
         OP_SRL:  data_o = {1'b0, data_i[WIDTH-1:1]};
         // The sign bit is copied into the vacated MSB.
         OP_SRA:  data_o = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
         default: data_o = data_i;
      endcase
   end

endmodule : shift_step
`default_nettype wire

// File: rtl/shift_seq.sv
`default_nettype none
// ============================================================================
// Module   : shift_seq
// Purpose  : Sequential shifter that moves the operand one bit position per
//            clock. Completion is signalled by a single-cycle done pulse, and
//            the result is held on data_out until the next accepted request.
// Ports    : clk      clock, rising edge
//            reset    synchronous active-high reset
//            start    request, accepted only in IDLE or DONE
//            op       [1:0]       00 LOAD, 01 SLL, 10 SRL, 11 SRA
//            data_in  [WIDTH-1:0] operand, captured on accept
//            shamt    [SHW-1:0]   shift amount, captured on accept
//            data_out [WIDTH-1:0] working / result register
//            busy     high while shifting
//            done     one-cycle completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module shift_seq
   import shift_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SHW   = DEF_SHW
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] data_in,
   input  logic [SHW-1:0]   shamt,
   output logic [WIDTH-1:0] data_out,
   output logic             busy,
   output logic             done
);

   localparam logic [SHW-1:0] c_WIDTH_SH = SHW'(WIDTH);
   localparam logic [SHW-1:0] c_ONE      = SHW'(1);

   state_e           state_q, state_d;
   logic [SHW-1:0]   cnt_q,   cnt_d;
   logic [1:0]       op_q,    op_d;
   logic [WIDTH-1:0] data_q,  data_d;

   logic             w_accept;
   logic [SHW-1:0]   w_cnt_load;
   logic [WIDTH-1:0] w_step;

   // A new request can only be taken when no shift is in flight.
   assign w_accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

   // LOAD never shifts. Amounts past WIDTH are clamped so that the result
   // saturates to zero or sign fill and latency stays bounded at WIDTH+1.
   always_comb begin
      w_cnt_load = shamt;
      if (op_e'(op) == OP_LOAD) begin
         w_cnt_load = '0;
      end else if (shamt > c_WIDTH_SH) begin
         w_cnt_load = c_WIDTH_SH;
      end
   end

   shift_step #(
      .WIDTH (WIDTH)
   ) u_shift_step (
      .op_i   (op_q),
      .data_i (data_q),
      .data_o (w_step)
   );

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next-state logic ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (w_accept) begin
               state_d = (w_cnt_load == '0) ? ST_DONE : ST_SHIFT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (cnt_q == c_ONE) begin
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- FSM: output decode ----------------
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      unique case (state_q)
         ST_SHIFT: busy = 1'b1;
         ST_DONE:  done = 1'b1;
         default: begin
            busy = 1'b0;
            done = 1'b0;
         end
      endcase
   end

   // ---------------- Datapath ----------------
   always_comb begin
      cnt_d  = cnt_q;
      op_d   = op_q;
      data_d = data_q;
      if (w_accept) begin
         cnt_d  = w_cnt_load;
         op_d   = op;
         data_d = data_in;
      end else if (state_q == ST_SHIFT) begin
         cnt_d  = cnt_q - c_ONE;
         data_d = w_step;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         op_q   <= OP_LOAD;
         data_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         op_q   <= op_d;
         data_q <= data_d;
      end
   end

   assign data_out = data_q;

endmodule : shift_seq
`default_nettype wire

// File: doc/shift_seq.md
# shift_seq

Sequential shift unit for the multicycle datapath. The control unit selects a shift amount (instruction shamt field, constant 16 for LUI-style shifts, or a register value) and hands it to this block with an operand and an operation code. The block shifts one bit position per clock cycle and signals completion with a one-cycle `done` pulse. The result stays on `data_out` for the register-file write-back mux.

## Interface
- `WIDTH`, 32, operand/result width.
- `SHW`, 6, shift-amount input width; must satisfy 2^SHW > WIDTH.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `op`  in  2  00 LOAD (pass-through), 01 SLL, 10 SRL, 11 SRA.
- `data_in`  in  WIDTH  operand, captured on the accepting edge.
- `shamt`  in  SHW  shift amount, captured on the accepting edge.
- `data_out`  out  WIDTH  working/result register.
- `busy`  out  1  high in SHIFT.
- `done`  out  1  one-cycle completion pulse (high in DONE).

## Operation
- States: IDLE, SHIFT, DONE.
- Accept: `start`=1 in IDLE or DONE.
  - `data_out`←`data_in`, `op_r`←`op`.
  - `cnt`←min(`shamt`, WIDTH); for LOAD, `cnt`←0.
  - Next state is DONE if `cnt` would be 0, else SHIFT.
- SHIFT, on each edge:
  - `data_out` shifts by one bit: SLL inserts 0 at LSB; SRL inserts 0 at MSB; SRA replicates the MSB.
  - `cnt` decrements.
  - When `cnt`==1 before the edge, next state is DONE.
- DONE:
  - `done`=1 for exactly one cycle.
  - Without `start`, next state is IDLE.
  - With `start`, a new operation is accepted (back-to-back).
- `start` in SHIFT is ignored; there is no queueing.
- `data_out` holds its value in IDLE and DONE until the next accept.
- Amounts ≥ WIDTH are clamped to WIDTH:
  - SLL/SRL result is all zeros.
  - SRA result is all copies of the operand sign bit.
- Reset values: state IDLE, `data_out`=0, `cnt`=0, `op_r`=00, `busy`=0, `done`=0. Reset overrides `start` and aborts any operation in progress.

## Timing
- Let n = effective count. Start is sampled at edge E0.
- `busy` is high for n cycles after E0.
- `done` is high during cycle n+1 after E0, so latency is n+1 cycles. LOAD and shamt=0 give `done` in the first cycle after E0.
- `data_out` is final in the `done` cycle; intermediate partial values are visible during SHIFT.
- Back-to-back: `start` during `done` is accepted at that edge, giving no idle bubble.
- Max latency is WIDTH+1 = 33 cycles.
- `busy` and `done` are never both high.
- Outputs are registered or decoded from the state register only; there is no combinational path from inputs to outputs.

## Structure
- Package `shift_pkg`: op encodings (`OP_LOAD`, `OP_SLL`, `OP_SRL`, `OP_SRA`), state encoding, default WIDTH/SHW constants.
- Sub-module `shift_step`: combinational one-bit shift of WIDTH bits selected by `op_r`. Instantiate it once in `shift_seq`.
- `shift_seq` holds the FSM, `cnt` (SHW bits), `op_r`, and `data_out`.

## Test plan
- Reset, then idle: outputs hold reset values. Then `start`, op=SLL, `data_in`=0x0000_0001, shamt=4 → `busy` for 4 cycles; `done` in cycle 5 with `data_out`=0x0000_0010.
- SRA, `data_in`=0x8000_0000, shamt=16 → `done` after 17 cycles, `data_out`=0xFFFF_8000. The same operand with SRL gives 0x0000_8000.
- Boundaries:
  - shamt=0 with SLL of 0x1234_5678 → `done` next cycle, value unchanged.
  - shamt=40 with SRA of 0x8000_0000 → clamped, 33-cycle latency, result 0xFFFF_FFFF.
  - shamt=40 with SLL → 0x0000_0000.
- `start` pulsed mid-SHIFT with different operands → ignored; the original result completes. Then `start` asserted in the `done` cycle with LOAD 0xDEAD_BEEF → accepted; `done` next cycle with 0xDEAD_BEEF.
- Assert `reset` at cycle 3 of a shamt=10 SLL → next cycle state IDLE, `data_out`=0, `busy`=0, and no `done` pulse follows.
